muldiv_iter: RTL and testbench
==============================

// Module: muldiv_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage.
//  Executes MULT/MULTU/DIV/DIVU on operands latched at start, with a start/busy/done handshake.
//  Produces a {hi,lo} pair for the HI/LO write path; the hazard unit stalls the pipe while busy.
//  Adds multiply, annul, divide-by-zero flagging and a width generic.
// PARAMETERS
//  WIDTH    32  operand width; result is 2*WIDTH as {hi,lo}
//  CNT_W     6  iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  start        in   1      request; sampled only in IDLE or DONE
//  op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  opa          in   WIDTH  multiplicand / dividend
//  opb          in   WIDTH  multiplier / divisor
//  annul        in   1      abort the operation in flight (pipeline flush)
//  busy         out  1      high in CALC
//  done         out  1      one-cycle pulse, high in DONE
//  result_hi    out  WIDTH  product[2W-1:W] or remainder
//  result_lo    out  WIDTH  product[W-1:0] or quotient
//  div_by_zero  out  1      last completed op was DIV/DIVU with opb==0
// BEHAVIOUR
//  - Reset (synchronous, active-high):
//    - state=IDLE; busy=0, done=0, result_hi=0, result_lo=0, div_by_zero=0.
//    - Any operation in flight is discarded.
//  - FSM states: IDLE -> CALC -> DONE -> IDLE.
//    - IDLE/DONE, start=1, annul=0: latch op/opa/opb, count=0, go to CALC.
//    - If that op is DIV/DIVU with opb==0: go straight to DONE instead.
//    - DONE with start=0: go to IDLE.
//    - CALC: one bit per cycle; after WIDTH CALC cycles go to DONE.
//    - CALC with annul=1: go to IDLE at the next edge. No done pulse; results and div_by_zero keep their prior values.
//    - start while in CALC is ignored; the requester holds start until done.
//    - start and annul in the same cycle: annul wins and start is not accepted.
//  - Latency, counting the start-sampling cycle as cycle 0:
//    - busy is high in cycles 1..WIDTH; done is high in cycle WIDTH+1.
//    - Divide-by-zero: done in cycle 1.
//    - Back-to-back: start held in the DONE cycle re-launches immediately, so the next op is in CALC in cycle WIDTH+2.
//  - Results:
//    - Updated only on the edge entering DONE; held until the next completion or reset.
//    - Valid whenever done=1 and remain readable afterwards.
//  - Signed ops (MULT, DIV):
//    - Operate on magnitudes.
//    - Product/quotient is negated when opa[W-1]^opb[W-1].
//    - Remainder takes the sign of opa.
//    - Two's-complement wrap applies: DIV MIN/-1 gives lo=MIN, hi=0.
//  - Unsigned ops: operands are treated as zero-extended.
//  - Divide: restoring, MSB-first. Remainder register is WIDTH+1 bits so the trial subtract never overflows.
//  - Multiply: shift-add over WIDTH cycles into a 2*WIDTH accumulator, with the sign fix-up applied on the final edge.
//  - Divide-by-zero: result_hi=opa (as latched), result_lo={WIDTH{1'b1}}, div_by_zero=1.
//  - div_by_zero is cleared on any other completion.
// CONFIGURATION
//  - MULDIV_FAST_MUL_EN defined:
//    - MULT/MULTU bypass CALC: IDLE/DONE -> DONE in one edge (done in cycle 1) using a registered W x W product.
//    - Divide behaviour is unchanged.
//  - MULDIV_FAST_MUL_EN undefined:
//    - Multiply is iterative with WIDTH+1 cycle latency, identical in timing to divide.
//    - No hardware multiplier is inferred.
// TESTING
//  1 MULTU opa=FFFFFFFF opb=FFFFFFFF
//    -> done cycle 33 (cycle 1 with FAST_MUL); hi=FFFFFFFE lo=00000001.
//  2 DIV opa=FFFFFFF9(-7) opb=00000002
//    -> done cycle 33; lo=FFFFFFFD(-3) hi=FFFFFFFF(-1) div_by_zero=0.
//  3 DIVU opa=12345678 opb=0
//    -> done cycle 1; hi=12345678 lo=FFFFFFFF div_by_zero=1.
//  4 DIV opa=80000000 opb=FFFFFFFF
//    -> lo=80000000 hi=00000000.
//    Then DIVU 64/8 held start in DONE -> relaunch, lo=8 hi=0 div_by_zero=0.
//  5 DIVU 100/7, annul at cycle 10
//    -> IDLE cycle 11, no done, hi/lo unchanged.
//    start+annul same cycle -> not accepted, busy stays 0.
//  6 rst asserted at cycle 15 of DIV
//    -> next cycle busy=0 done=0 hi=lo=0.
//    Fresh start runs normally.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) with start/busy/done handshake and annul.
// Optional MULDIV_FAST_MUL_EN: single-edge registered multiply, divide stays iterative.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one multiply/divide bit per cycle, busy high
  // DONE  | results valid, done pulse; start here relaunches
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       count;
  logic                   is_div;
  logic                   neg_q;
  logic                   neg_r;
  logic [WIDTH:0]         rem;
  logic [WIDTH-1:0]       quo;
  logic [WIDTH-1:0]       dvs;

  logic                   launch;
  logic                   in_signed;
  logic                   in_zero_div;
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;

  logic [WIDTH:0]         sum;
  logic [WIDTH:0]         rem_sh;
  logic [WIDTH+1:0]       diff;
  logic [WIDTH:0]         nxt_rem;
  logic [WIDTH-1:0]       nxt_quo;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       fin_q;
  logic [WIDTH-1:0]       fin_r;
  logic                   last_iter;

  assign launch      = (state != CALC) && start && !annul;
  assign in_signed   = !op[0];
  assign in_zero_div = op[1] && (opb == '0);
  assign last_iter   = (count == CNT_W'(WIDTH - 1));

  always_comb begin
    mag_a = (in_signed && opa[WIDTH-1]) ? -opa : opa;
    mag_b = (in_signed && opb[WIDTH-1]) ? -opb : opb;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  always_comb begin
    if (in_signed)
      fast_prod = {{WIDTH{opa[WIDTH-1]}}, opa} * {{WIDTH{opb[WIDTH-1]}}, opb};
    else
      fast_prod = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
  end
`endif

  // Datapath shared by both ops: rem is the product high half / partial remainder,
  // quo is the multiplier being shifted out / quotient being shifted in, dvs is multiplicand / divisor.
  always_comb begin
    sum    = rem + (quo[0] ? {1'b0, dvs} : '0);
    rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs};
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        nxt_rem = diff[WIDTH:0];
        nxt_quo = {quo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_rem = rem_sh;
        nxt_quo = {quo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_rem = {1'b0, sum[WIDTH:1]};
      nxt_quo = {sum[0], quo[WIDTH-1:1]};
    end
    prod = {nxt_rem[WIDTH-1:0], nxt_quo};
    if (neg_q)
      prod = -prod;
    fin_q = neg_q ? -nxt_quo : nxt_quo;
    fin_r = neg_r ? -nxt_rem[WIDTH-1:0] : nxt_rem[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (launch) begin
            count  <= '0;
            is_div <= op[1];
            neg_q  <= in_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
            neg_r  <= in_signed && opa[WIDTH-1];
            rem    <= '0;
            quo    <= op[1] ? mag_a : mag_b;
            dvs    <= op[1] ? mag_b : mag_a;
            if (in_zero_div) begin
              state       <= DONE;
              done        <= 1'b1;
              result_hi   <= opa;
              result_lo   <= '1;
              div_by_zero <= 1'b1;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!op[1]) begin
              state       <= DONE;
              done        <= 1'b1;
              result_hi   <= fast_prod[2*WIDTH-1:WIDTH];
              result_lo   <= fast_prod[WIDTH-1:0];
              div_by_zero <= 1'b0;
            end
`endif
            else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (annul) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem   <= nxt_rem;
            quo   <= nxt_quo;
            count <= count + 1'b1;
            if (last_iter) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              result_hi   <= is_div ? fin_r : prod[2*WIDTH-1:WIDTH];
              result_lo   <= is_div ? fin_q : prod[WIDTH-1:0];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: scoreboard of expected {hi,lo,dbz} checked at each done pulse,
// plus latency, annul, start/annul collision and mid-operation reset checks.
module tb_muldiv_iter;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          annul;
  logic          busy;
  logic          done;
  logic [W-1:0]  result_hi;
  logic [W-1:0]  result_lo;
  logic          div_by_zero;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  muldiv_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .annul(annul), .busy(busy), .done(done), .result_hi(result_hi),
    .result_lo(result_lo), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request in the current cycle (cycle 0) and record what it must produce.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    exp_t e;
    e.hi = eh; e.lo = el; e.dbz = ed;
    sb.push_back(e);
    op = o; opa = a; opb = b; start = 1'b1;
  endtask

  // Returns in the DONE cycle (or after the cycle budget).
  task automatic wait_done(input string tag, input int exp_lat);
    int   cyc;
    logic busy1;
    exp_t e;
    cyc   = 0;
    busy1 = 1'b0;
    do begin
      step();
      if (cyc == 0) start = 1'b0;
      cyc++;
      if (cyc == 1) busy1 = busy;
    end while (!done && cyc < 200);
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_busy1"}, 64'(busy1), 64'(exp_lat > 1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_hi"}, 64'(result_hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(result_lo), 64'(e.lo));
      chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
    end
  endtask

  initial begin
    logic saw_done;
    rst = 1'b1; start = 1'b0; annul = 1'b0; op = 2'b00; opa = '0; opb = '0;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(result_hi), 64'd0);
    chk("rst_lo", 64'(result_lo), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    step();

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    wait_done("multu_max", MUL_LAT);
    step();
    chk("done_pulse", 64'(done), 64'd0);
    chk("hold_lo", 64'(result_lo), 64'd1);

    launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    wait_done("mult_neg", MUL_LAT);
    step();

    launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done("div_m7_2", DIV_LAT);
    step();

    launch(2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    wait_done("divu_zero", 1);
    step();

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    wait_done("div_min", DIV_LAT);
    // start held in the DONE cycle relaunches
    launch(2'b11, 32'd64, 32'd8, 32'd0, 32'd8, 1'b0);
    wait_done("b2b_divu", DIV_LAT);
    step();

    launch(2'b11, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    void'(sb.pop_back());
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    annul = 1'b1;
    step();
    annul = 1'b0;
    chk("annul_busy", 64'(busy), 64'd0);
    chk("annul_done", 64'(done), 64'd0);
    chk("annul_hi", 64'(result_hi), 64'd0);
    chk("annul_lo", 64'(result_lo), 64'd8);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      saw_done |= done;
    end
    chk("annul_nodone", 64'(saw_done), 64'd0);

    start = 1'b1; annul = 1'b1; op = 2'b11; opa = 32'd100; opb = 32'd7;
    step();
    start = 1'b0; annul = 1'b0;
    chk("collide_busy", 64'(busy), 64'd0);
    step();
    chk("collide_busy2", 64'(busy), 64'd0);

    launch(2'b10, 32'd1000, 32'hFFFF_FFFD, 32'd0, 32'd0, 1'b0);
    void'(sb.pop_back());
    step();
    start = 1'b0;
    for (int i = 1; i < 15; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_hi", 64'(result_hi), 64'd0);
    chk("mrst_lo", 64'(result_lo), 64'd0);

    launch(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_done("fresh_divu", DIV_LAT);
    step();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
